// File: rtl/tcycle_scheduler.sv
// Purpose: divides clk_in into T-cycles/M-cycles and NUM_SLOTS shared-memory slots per T-cycle, with run/pause/step control.
// Latency: first tclk/mclk pulse one clock after leaving PAUSED; tclk period CLK_PER_TCYCLE, mclk period CLK_PER_TCYCLE*TCYCLES_PER_MCYCLE.
// Backpressure: none; run_in is sampled only at M-cycle ends while running, step_in only while PAUSED (never queued).
// Ports:
//   clk_in, rst_in (sync, active-high), run_in (level), step_in (pulse)
//   running_out, phase_out, tidx_out, tclk_out, mclk_out, slot_active_out, slot_start_out, mcycle_count_out
module tcycle_scheduler #(
   parameter int CLK_PER_TCYCLE     = 24,
   parameter int NUM_SLOTS          = 4,
   parameter int SLOT_LEN           = 6,
   parameter int TCYCLES_PER_MCYCLE = 4,
   parameter int MCOUNT_W           = 16,
   localparam int PHASE_W = (CLK_PER_TCYCLE > 1) ? $clog2(CLK_PER_TCYCLE) : 1,
   localparam int TIDX_W  = (TCYCLES_PER_MCYCLE > 1) ? $clog2(TCYCLES_PER_MCYCLE) : 1
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                run_in,
   input  logic                step_in,
   output logic                running_out,
   output logic [PHASE_W-1:0]  phase_out,
   output logic [TIDX_W-1:0]   tidx_out,
   output logic                tclk_out,
   output logic                mclk_out,
   output logic [NUM_SLOTS-1:0] slot_active_out,
   output logic [NUM_SLOTS-1:0] slot_start_out,
   output logic [MCOUNT_W-1:0] mcycle_count_out
);

   typedef enum logic [1:0] {
      PAUSED = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2
   } state_t;

   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_PER_TCYCLE - 1);
   localparam logic [TIDX_W-1:0]  TIDX_LAST  = TIDX_W'(TCYCLES_PER_MCYCLE - 1);

   state_t               state, state_nxt;
   logic [PHASE_W-1:0]   phase;
   logic [TIDX_W-1:0]    tidx;
   logic [MCOUNT_W-1:0]  mcycle_count;

   logic                 advancing;   // registered-state view, drives counting
   logic                 adv_out;     // additionally forced low while reset is held
   logic                 end_m;
   int unsigned          phase_int;

   assign advancing = (state != PAUSED);
   assign end_m     = advancing && (phase == PHASE_LAST) && (tidx == TIDX_LAST);
   assign adv_out   = advancing && !rst_in;
   assign phase_int = 32'(phase);

   // State register and counters
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state        <= PAUSED;
         phase        <= '0;
         tidx         <= '0;
         mcycle_count <= '0;
      end else begin
         state <= state_nxt;
         if (advancing) begin
            if (phase == PHASE_LAST) begin
               phase <= '0;
               tidx  <= (tidx == TIDX_LAST) ? '0 : tidx + 1'b1;
            end else begin
               phase <= phase + 1'b1;
            end
         end
         if (end_m) begin
            mcycle_count <= mcycle_count + 1'b1;
         end
      end
   end

   // Next state: leaving RUN/STEP happens only at end_m so PAUSED always sees phase=tidx=0
   always_comb begin
      state_nxt = state;
      unique case (state)
         PAUSED: begin
            if (run_in)       state_nxt = RUN;
            else if (step_in) state_nxt = STEP;
         end
         RUN: begin
            if (end_m && !run_in) state_nxt = PAUSED;
         end
         STEP: begin
            if (end_m) state_nxt = run_in ? RUN : PAUSED;
         end
         default: state_nxt = PAUSED;
      endcase
   end

   // Output decode; everything is forced to zero while reset is asserted
   always_comb begin
      running_out      = adv_out;
      phase_out        = rst_in ? '0 : phase;
      tidx_out         = rst_in ? '0 : tidx;
      mcycle_count_out = rst_in ? '0 : mcycle_count;
      tclk_out         = adv_out && (phase == '0);
      mclk_out         = adv_out && (phase == '0) && (tidx == '0);
      slot_active_out  = '0;
      slot_start_out   = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         // phases at or beyond NUM_SLOTS*SLOT_LEN fall through: settle gap
         if (adv_out && (phase_int >= 32'(k * SLOT_LEN)) && (phase_int < 32'((k + 1) * SLOT_LEN)))
            slot_active_out[k] = 1'b1;
         if (adv_out && (phase_int == 32'(k * SLOT_LEN)))
            slot_start_out[k] = 1'b1;
      end
   end

endmodule

// File: tb/tb_tcycle_scheduler.sv
// Purpose: scoreboard bench driving three scheduler configurations with shared run/step/reset stimulus.
// Latency: expected outputs are queued one clock-phase ahead and popped by per-DUT monitors on the falling edge.
// Backpressure: none; the monitors check every clock.
module tb_tcycle_scheduler;

   typedef struct {
      int unsigned phase;
      int unsigned tidx;
      int unsigned count;
      bit          running;
      bit          tclk;
      bit          mclk;
      bit [7:0]    act;
      bit [7:0]    start;
   } exp_t;

   // Configurations: 0 = defaults, 1 = tiny (2/1/1/1, 4-bit counter), 2 = three slots with settle gap
   int CPT [3] = '{24, 2, 24};
   int NS  [3] = '{4, 1, 3};
   int SL  [3] = '{6, 1, 6};
   int TPM [3] = '{4, 1, 4};
   int CW  [3] = '{16, 4, 16};

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic run = 1'b0;
   logic step = 1'b0;

   always #5 clk = ~clk;

   // DUT 0
   logic        r0, t0, m0;
   logic [4:0]  p0;
   logic [1:0]  x0;
   logic [3:0]  a0, s0;
   logic [15:0] c0;
   tcycle_scheduler dut0 (
      .clk_in(clk), .rst_in(rst), .run_in(run), .step_in(step),
      .running_out(r0), .phase_out(p0), .tidx_out(x0), .tclk_out(t0), .mclk_out(m0),
      .slot_active_out(a0), .slot_start_out(s0), .mcycle_count_out(c0));

   // DUT 1
   logic        r1, t1, m1;
   logic [0:0]  p1;
   logic [0:0]  x1;
   logic [0:0]  a1, s1;
   logic [3:0]  c1;
   tcycle_scheduler #(.CLK_PER_TCYCLE(2), .NUM_SLOTS(1), .SLOT_LEN(1),
                      .TCYCLES_PER_MCYCLE(1), .MCOUNT_W(4)) dut1 (
      .clk_in(clk), .rst_in(rst), .run_in(run), .step_in(step),
      .running_out(r1), .phase_out(p1), .tidx_out(x1), .tclk_out(t1), .mclk_out(m1),
      .slot_active_out(a1), .slot_start_out(s1), .mcycle_count_out(c1));

   // DUT 2
   logic        r2, t2, m2;
   logic [4:0]  p2;
   logic [1:0]  x2;
   logic [2:0]  a2, s2;
   logic [15:0] c2;
   tcycle_scheduler #(.NUM_SLOTS(3)) dut2 (
      .clk_in(clk), .rst_in(rst), .run_in(run), .step_in(step),
      .running_out(r2), .phase_out(p2), .tidx_out(x2), .tclk_out(t2), .mclk_out(m2),
      .slot_active_out(a2), .slot_start_out(s2), .mcycle_count_out(c2));

   exp_t got [3];
   always_comb begin
      got[0] = '{32'(p0), 32'(x0), 32'(c0), r0, t0, m0, 8'(a0), 8'(s0)};
      got[1] = '{32'(p1), 32'(x1), 32'(c1), r1, t1, m1, 8'(a1), 8'(s1)};
      got[2] = '{32'(p2), 32'(x2), 32'(c2), r2, t2, m2, 8'(a2), 8'(s2)};
   end

   // Reference model: mode 0=paused, 1=free-run, 2=single M-cycle; adv counts advancing clocks since reset
   int     mode [3];
   longint adv  [3];
   exp_t   q [3][$];
   bit     started = 1'b0;
   int     total = 0;
   int     bad   = 0;

   function automatic exp_t model_out(int i, bit r);
      exp_t   e;
      longint ph, ti, k;
      e = '{0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0};
      if (!r) begin
         ph = adv[i] % CPT[i];
         ti = (adv[i] / CPT[i]) % TPM[i];
         e.phase   = int'(ph);
         e.tidx    = int'(ti);
         e.count   = int'((adv[i] / (CPT[i] * TPM[i])) % (64'd1 << CW[i]));
         e.running = (mode[i] != 0);
         if (mode[i] != 0) begin
            e.tclk = (ph == 0);
            e.mclk = (ph == 0) && (ti == 0);
            k = ph / SL[i];
            if (k < NS[i]) begin
               e.act[k] = 1'b1;
               if (ph % SL[i] == 0) e.start[k] = 1'b1;
            end
         end
      end
      return e;
   endfunction

   task automatic model_edge(int i);
      if (rst) begin
         mode[i] = 0;
         adv[i]  = 0;
      end else if (mode[i] == 0) begin
         if (run)       mode[i] = 1;
         else if (step) mode[i] = 2;
      end else begin
         adv[i] = adv[i] + 1;
         if (adv[i] % (CPT[i] * TPM[i]) == 0) begin
            if (mode[i] == 2) mode[i] = run ? 1 : 0;
            else if (!run)    mode[i] = 0;
         end
      end
   endtask

   // One clock: update models at the edge, then drive new inputs and queue expected outputs
   task automatic cyc(input bit r, input bit ru, input bit st);
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_edge(i);
      #1;
      rst  = r;
      run  = ru;
      step = st;
      for (int i = 0; i < 3; i++) q[i].push_back(model_out(i, r));
      started = 1'b1;
   endtask

   task automatic chk(int i, string nm, int unsigned g, int unsigned w);
      total++;
      if (g !== w) begin
         bad++;
         $display("FAIL d%0d %s got=%0d want=%0d t=%0t", i, nm, g, w, $time);
      end
   endtask

   task automatic monitor(int i);
      exp_t e;
      if (!started) return;
      if (q[i].size() == 0) begin
         chk(i, "queue_underflow", 0, 1);
         return;
      end
      e = q[i].pop_front();
      chk(i, "running", 32'(got[i].running), 32'(e.running));
      chk(i, "phase",   got[i].phase, e.phase);
      chk(i, "tidx",    got[i].tidx,  e.tidx);
      chk(i, "tclk",    32'(got[i].tclk), 32'(e.tclk));
      chk(i, "mclk",    32'(got[i].mclk), 32'(e.mclk));
      chk(i, "slot_active", 32'(got[i].act), 32'(e.act));
      chk(i, "slot_start",  32'(got[i].start), 32'(e.start));
      chk(i, "mcycle_count", got[i].count, e.count);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) monitor(i);
   end

   initial begin
      int  guard;
      bit  rl;
      for (int i = 0; i < 3; i++) begin
         mode[i] = 0;
         adv[i]  = 0;
      end
      // reset, then free-run
      repeat (3) cyc(1, 0, 0);
      repeat (200) cyc(0, 1, 0);
      // reset in the middle of an M-cycle (phase 10, tidx 2 of config 0), run held high
      repeat (3) cyc(1, 0, 0);
      guard = 0;
      while (!(mode[0] == 1 && adv[0] == 58) && guard < 200) begin
         cyc(0, 1, 0);
         guard++;
      end
      cyc(1, 1, 0);
      repeat (150) cyc(0, 1, 0);
      // drop run_in at phase 30 of an M-cycle; the M-cycle must complete
      guard = 0;
      while (adv[0] % 96 != 30 && guard < 200) begin
         cyc(0, 1, 0);
         guard++;
      end
      repeat (100) cyc(0, 0, 0);
      // single step, with ignored step pulses while stepping
      cyc(0, 0, 1);
      for (int c = 0; c < 120; c++) cyc(0, 0, (c % 17) == 5);
      // run and step together: free-run wins
      cyc(0, 1, 1);
      repeat (150) cyc(0, 1, 0);
      repeat (120) cyc(0, 0, 0);
      // random phase
      rl = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 59) == 0) rl = ~rl;
         cyc($urandom_range(0, 699) == 0, rl, $urandom_range(0, 19) == 0);
      end
      cyc(0, 0, 0);
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) chk(i, "queue_drained", q[i].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
